// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding and default sizing for the CPU program loader.
package program_loader_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_RDY, WAIT_ACK, WAIT_DONE} state_e;
    localparam logic [7:0] PROG_IDLE = 8'h00;
    localparam int DEF_PROG_BYTES = 16;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/program_loader_byte_fifo.sv
// byte_fifo: read-ahead byte FIFO with flush; the head byte is always visible on dout_o.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  logic [7:0]              din_i,
    output logic [7:0]              dout_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic do_push, do_pop;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= din_i;
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/program_loader.sv
// program_loader: buffers a host program image and feeds it to the CPU programming port
// one byte per ready handshake, aborting on a stalled handshake.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int PROG_BYTES     = DEF_PROG_BYTES,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   host_data,
    input  logic                         host_valid,
    output logic                         host_ready,
    input  logic                         host_start,
    input  logic                         cpu_ready,
    input  logic                         cpu_done_load,
    output logic [7:0]                   prog_data,
    output logic                         programming,
    output logic                         busy,
    output logic                         load_ok,
    output logic                         err_short,
    output logic                         err_timeout,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(PROG_BYTES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
    state_e        state_q;
    logic          rdy_q, programming_q, load_ok_q, err_short_q, err_timeout_q;
    logic [7:0]    prog_data_q;
    logic [SW-1:0] sent_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic          rise, fall, tmo_hit, start_ok, done, push, pop, last, programming_d;
    logic [7:0]    prog_data_d;
    assign rise          = cpu_ready & ~rdy_q;
    assign fall          = ~cpu_ready & rdy_q;
    assign tmo_hit       = (state_q != IDLE) && (tmo_q == TMO_MAX);
    assign start_ok      = (state_q == IDLE) && host_start && (fifo_count >= CW'(PROG_BYTES));
    assign done          = (state_q == WAIT_DONE) && cpu_done_load && !tmo_hit;
    assign pop           = (state_q == WAIT_ACK) && fall && !tmo_hit && !fifo_empty;
    assign last          = sent_q == SW'(PROG_BYTES - 1);
    assign host_ready    = (state_q == IDLE) && !fifo_full;
    assign push          = host_valid && host_ready;
    // prog_data follows the next programming level so it drops to idle with the port.
    assign programming_d = start_ok | (programming_q & ~tmo_hit & ~done);
    assign prog_data_d   = programming_d ? fifo_dout : PROG_IDLE;
    assign programming   = programming_q;
    assign prog_data     = prog_data_q;
    assign busy          = state_q != IDLE;
    assign load_ok       = load_ok_q;
    assign err_short     = err_short_q;
    assign err_timeout   = err_timeout_q;
    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (tmo_hit),
        .din_i   (host_data),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q       <= IDLE;
            rdy_q         <= 1'b0;
            programming_q <= 1'b0;
            prog_data_q   <= PROG_IDLE;
            load_ok_q     <= 1'b0;
            err_short_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            sent_q        <= '0;
            tmo_q         <= '0;
        end else begin
            rdy_q         <= cpu_ready;
            programming_q <= programming_d;
            prog_data_q   <= prog_data_d;
            load_ok_q     <= done;
            tmo_q         <= (state_q == IDLE) ? '0 : tmo_q + 1'b1;
            if (tmo_hit) begin
                state_q       <= IDLE;
                err_timeout_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE:
                        if (start_ok) begin
                            state_q       <= WAIT_RDY;
                            err_short_q   <= 1'b0;
                            err_timeout_q <= 1'b0;
                            sent_q        <= '0;
                        end else if (host_start) begin
                            err_short_q <= 1'b1;
                        end
                    WAIT_RDY:
                        if (rise) begin
                            state_q <= WAIT_ACK;
                            tmo_q   <= '0;
                        end
                    WAIT_ACK:
                        if (fall) begin
                            sent_q  <= sent_q + 1'b1;
                            state_q <= last ? WAIT_DONE : WAIT_RDY;
                            tmo_q   <= '0;
                        end
                    WAIT_DONE:
                        if (cpu_done_load) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed-random bench with a queue model of the buffered image and a CPU handshake model.
module tb_program_loader;
    localparam int PB = 16;
    localparam int DEPTH = 32;
    localparam int TMO = 1024;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] host_data = 8'h00;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic       host_start = 1'b0;
    logic       cpu_ready = 1'b0;
    logic       cpu_done_load = 1'b0;
    logic [7:0] prog_data;
    logic       programming, busy, load_ok, err_short, err_timeout;
    logic [5:0] fifo_count;
    int passed = 0;
    int total = 0;
    logic [7:0] q[$];
    program_loader #(.PROG_BYTES(PB), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .host_data     (host_data),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .host_start    (host_start),
        .cpu_ready     (cpu_ready),
        .cpu_done_load (cpu_done_load),
        .prog_data     (prog_data),
        .programming   (programming),
        .busy          (busy),
        .load_ok       (load_ok),
        .err_short     (err_short),
        .err_timeout   (err_timeout),
        .fifo_count    (fifo_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            host_valid = 1'b1;
            host_data  = 8'($urandom);
            chk("host_ready", host_ready, q.size() < DEPTH);
            if (q.size() < DEPTH) q.push_back(host_data);
            step();
        end
        host_valid = 1'b0;
        chk("fifo_count_push", fifo_count, q.size());
    endtask
    task automatic short_start();
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        chk("err_short", err_short, 1);
        chk("short_busy", busy, 0);
        chk("short_programming", programming, 0);
        chk("short_count", fifo_count, q.size());
        chk("short_host_ready", host_ready, 1);
    endtask
    task automatic feed_byte(input logic [7:0] exp, input bit early);
        int lo = $urandom_range(2, 4);
        int hi = $urandom_range(1, 3);
        for (int i = 0; i < lo; i++) begin
            cpu_done_load = early && (i == 0);
            step();
        end
        cpu_done_load = 1'b0;
        cpu_ready = 1'b1;
        for (int i = 0; i < hi; i++) begin
            step();
            chk("prog_data", prog_data, exp);
        end
        chk("programming_hi", programming, 1);
        cpu_ready = 1'b0;
    endtask
    task automatic do_load();
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_programming", programming, 1);
        chk("start_err_short", err_short, 0);
        chk("start_err_timeout", err_timeout, 0);
        for (int b = 0; b < PB; b++) feed_byte(q.pop_front(), b == 3);
        step();
        chk("wait_done_busy", busy, 1);
        chk("wait_done_programming", programming, 1);
        repeat ($urandom_range(0, 3)) step();
        cpu_done_load = 1'b1;
        step();
        cpu_done_load = 1'b0;
        chk("done_programming", programming, 0);
        chk("load_ok_pulse", load_ok, 1);
        chk("done_busy", busy, 0);
        chk("done_prog_data", prog_data, 0);
        step();
        chk("load_ok_single", load_ok, 0);
        chk("done_count", fifo_count, q.size());
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_host_ready", host_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_programming", programming, 0);
        chk("rst_prog_data", prog_data, 0);
        chk("rst_load_ok", load_ok, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_count", fifo_count, 0);
        push_n(5);
        short_start();
        push_n(15);
        do_load();
        short_start();
        push_n(12);
        do_load();
        push_n(DEPTH + 2);
        chk("full_host_ready", host_ready, 0);
        do_load();
        do_load();
        push_n(PB);
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        n = 0;
        while (busy && n < 1200) begin
            step();
            n++;
        end
        chk("timeout_cycles", n, TMO);
        chk("timeout_err", err_timeout, 1);
        chk("timeout_programming", programming, 0);
        chk("timeout_count", fifo_count, 0);
        chk("timeout_prog_data", prog_data, 0);
        q.delete();
        push_n(PB);
        cpu_ready = 1'b1;
        step();
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        repeat (3) step();
        cpu_ready = 1'b0;
        repeat (3) step();
        chk("no_false_rise", fifo_count, PB);
        for (int b = 0; b < 7; b++) feed_byte(q.pop_front(), 1'b0);
        cpu_ready = 1'b1;
        step();
        step();
        #3 rst = 1'b1;
        #1;
        chk("arst_programming", programming, 0);
        chk("arst_prog_data", prog_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_count", fifo_count, 0);
        cpu_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        q.delete();
        push_n(PB);
        do_load();
        repeat (3) begin
            push_n($urandom_range(16, 24) - q.size());
            do_load();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
